flash_arbiter: RTL and testbench

- Shares the single Flash bridge (addr/data/direction_rw, fb_start/fb_done handshake) between two on-chip requesters: score writer (req0) and display reader (req1).
- Arbitrates round-robin and latches the winner's command.
- Issues one-cycle fb_start pulses and waits for fb_done, with a watchdog timeout.
- Returns per-requester done/error pulses.

---
 rtl/flash_pkg.sv | 24 ++
 rtl/flash_rr_picker.sv | 21 ++
 rtl/flash_arbiter.sv | 153 +++++++++++++++
 tb/tb_flash_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash bridge arbiter: FSM encoding, bus width
// defaults and requester indices.
package flash_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic REQ_SCORE = 1'b0;
  localparam logic REQ_DISP  = 1'b1;

  // 3-bit encoding kept identical to the bridge's own state register width
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    WAIT    = ST_WAIT,
    RELEASE = ST_RELEASE
  } state_e;

endpackage

// File: rtl/flash_rr_picker.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module flash_rr_picker (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |valid_i;
    grant_idx_o   = 1'b0;
    case (valid_i)
      2'b01:   grant_idx_o = 1'b0;
      2'b10:   grant_idx_o = 1'b1;
      2'b11:   grant_idx_o = ~last_grant_i;
      default: grant_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one flash bridge between the score writer (req0) and display reader
// (req1): round-robin grant, single-cycle fb_start, fb_done wait with watchdog.
module flash_arbiter
  import flash_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic              req1_err,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_direction_rw,
  output logic              fb_start,
  input  logic              fb_done,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [7:0]          wd_q, wd_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_id_q, grant_id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rw_q, rw_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic [1:0]          ready_q, ready_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          err_q, err_d;

  logic                pick_valid;
  logic                pick_idx;

  flash_rr_picker u_picker (
    .valid_i       ({req1_valid, req0_valid}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (pick_valid),
    .grant_idx_o   (pick_idx)
  );

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      rw_q         <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rw_q         <= rw_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Outputs are registered, so each decision is made one state ahead of
  // where it becomes visible (e.g. fb_start is raised on the IDLE->ISSUE edge).
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rw_d         = rw_q;
    start_d      = 1'b0;
    ready_d      = '0;
    done_d       = '0;
    err_d        = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d        = pick_idx;
          addr_d            = (pick_idx == REQ_DISP) ? req1_addr  : req0_addr;
          data_d            = (pick_idx == REQ_DISP) ? req1_wdata : req0_wdata;
          rw_d              = (pick_idx == REQ_DISP) ? req1_rw    : req0_rw;
          ready_d[pick_idx] = 1'b1;
          start_d           = 1'b1;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 8'd1;
        // completion takes priority over a timeout landing on the same cycle
        if (fb_done) begin
          done_d[grant_id_q] = 1'b1;
          state_d            = RELEASE;
        end else if (wd_q == WD_LIMIT) begin
          err_d[grant_id_q] = 1'b1;
          state_d           = RELEASE;
        end
      end
      RELEASE: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign req0_ready      = ready_q[REQ_SCORE];
  assign req1_ready      = ready_q[REQ_DISP];
  assign req0_done       = done_q[REQ_SCORE];
  assign req1_done       = done_q[REQ_DISP];
  assign req0_err        = err_q[REQ_SCORE];
  assign req1_err        = err_q[REQ_DISP];
  assign fb_addr         = addr_q;
  assign fb_data         = data_q;
  assign fb_direction_rw = rw_q;
  assign fb_start        = start_q;
  assign busy            = busy_q;
  assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: directed vector table, hand-written reset/idle
// sequences and randomized transactions against a transaction-level model.
module tb_flash_arbiter;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_rw, req1_valid, req1_rw;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       req0_ready, req0_done, req0_err;
  logic       req1_ready, req1_done, req1_err;
  logic [7:0] fb_addr, fb_data;
  logic       fb_direction_rw, fb_start, fb_done, busy, grant_id;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;
  logic model_last;

  always #10 clk = ~clk;

  flash_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_50MHZ(clk), .RST(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_err(req1_err),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_direction_rw(fb_direction_rw),
    .fb_start(fb_start), .fb_done(fb_done), .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    logic [1:0] mask;
    logic       rw0;
    logic [7:0] a0;
    logic [7:0] d0;
    logic       rw1;
    logic [7:0] a1;
    logic [7:0] d1;
    int         dly;
    bit         keep;
    logic       win;
    bit         done;
  } vec_t;

  vec_t vecs[6];

  // Bus-wide invariants, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (fb_start) start_cnt++;
      if ((req0_ready && req1_ready) || (req0_done && req1_done) || (req0_err && req1_err)) begin
        failures++;
        $display("FAIL exclusive_pulse ready=%b%b done=%b%b err=%b%b required no overlap",
                 req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic model_pick(input logic [1:0] m);
    if (m == 2'b11) return ~model_last;
    return m[1];
  endfunction

  task automatic set_cmd(input logic rw0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic rw1, input logic [7:0] a1, input logic [7:0] d1);
    req0_rw = rw0; req0_addr = a0; req0_wdata = d0;
    req1_rw = rw1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    fb_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  // One full transaction from the arbiter sitting in IDLE. dly is the number
  // of cycles after the fb_start cycle at which the bridge raises fb_done;
  // anything beyond TO means the bridge never answers.
  task automatic do_txn(input logic [1:0] mask, input int dly, input bit keep,
                        input logic win, input bit exp_done);
    int e;
    logic [7:0] ea, ed;
    logic erw;
    ea  = win ? req1_addr  : req0_addr;
    ed  = win ? req1_wdata : req0_wdata;
    erw = win ? req1_rw    : req0_rw;
    req0_valid = mask[0];
    req1_valid = mask[1];
    tick();
    chkb("ready0", req0_ready, win == 1'b0);
    chkb("ready1", req1_ready, win == 1'b1);
    chkb("fb_start_issue", fb_start, 1'b1);
    chkb("grant_id", grant_id, win);
    chkv("fb_addr", fb_addr, ea);
    chkv("fb_data", fb_data, ed);
    chkb("fb_rw", fb_direction_rw, erw);
    chkb("busy_issue", busy, 1'b1);
    chkv("pulses_issue", 8'({req0_done, req0_err, req1_done, req1_err}), 8'h00);
    if (!keep) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    e = (dly <= TO) ? dly : TO;
    for (int k = 1; k <= e; k++) begin
      tick();
      fb_done = (k == dly);
      chkb("fb_start_wait", fb_start, 1'b0);
      chkb("busy_wait", busy, 1'b1);
      chkv("pulses_wait", 8'({req0_ready, req1_ready, req0_done, req0_err, req1_done, req1_err}), 8'h00);
      chkv("addr_hold", fb_addr, ea);
    end
    tick();
    fb_done = 1'b0;
    chkb("done0", req0_done, exp_done && (win == 1'b0));
    chkb("done1", req1_done, exp_done && (win == 1'b1));
    chkb("err0", req0_err, !exp_done && (win == 1'b0));
    chkb("err1", req1_err, !exp_done && (win == 1'b1));
    chkb("busy_release", busy, 1'b1);
    chkb("fb_start_release", fb_start, 1'b0);
    chkv("ready_release", 8'({req0_ready, req1_ready}), 8'h00);
    tick();
    chkb("busy_idle", busy, 1'b0);
    chkv("pulses_idle", 8'({req0_ready, req1_ready, req0_done, req0_err, req1_done, req1_err}), 8'h00);
    chkb("grant_id_idle", grant_id, win);
    chkv("data_hold", fb_data, ed);
    model_last = win;
  endtask

  initial begin
    int s0;
    logic [1:0] m;
    int d;
    bit kp;
    logic w;

    set_cmd(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    apply_reset();
    rst = 1'b1;
    tick();
    chkb("rst_fb_start", fb_start, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkv("rst_pulses", 8'({req0_ready, req1_ready, req0_done, req0_err, req1_done, req1_err}), 8'h00);
    chkv("rst_fb_addr", fb_addr, 8'h00);
    chkv("rst_fb_data", fb_data, 8'h00);
    chkb("rst_fb_rw", fb_direction_rw, 1'b0);
    chkb("rst_grant_id", grant_id, 1'b0);
    rst = 1'b0;

    vecs[0] = '{2'b01, 1'b0, 8'h12, 8'hA5, 1'b0, 8'h00, 8'h00, 3,   1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'b01, 1'b1, 8'h20, 8'h5A, 1'b1, 8'h99, 8'h11, 1,   1'b0, 1'b0, 1'b1};
    vecs[2] = '{2'b11, 1'b0, 8'h21, 8'h01, 1'b1, 8'h34, 8'h77, 2,   1'b1, 1'b1, 1'b1};
    vecs[3] = '{2'b10, 1'b0, 8'h00, 8'h00, 1'b0, 8'h40, 8'hC3, 10,  1'b0, 1'b1, 1'b1};
    vecs[4] = '{2'b10, 1'b0, 8'h00, 8'h00, 1'b1, 8'h41, 8'h00, 255, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'b11, 1'b0, 8'h7E, 8'hE7, 1'b1, 8'h42, 8'h00, 4,   1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      set_cmd(vecs[i].rw0, vecs[i].a0, vecs[i].d0, vecs[i].rw1, vecs[i].a1, vecs[i].d1);
      do_txn(vecs[i].mask, vecs[i].dly, vecs[i].keep, vecs[i].win, vecs[i].done);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Simultaneous valids straight out of reset, then sustained contention
    apply_reset();
    set_cmd(1'b0, 8'h56, 8'h3C, 1'b1, 8'h34, 8'h00);
    s0 = start_cnt;
    do_txn(2'b11, 2, 1'b1, 1'b0, 1'b1);
    do_txn(2'b11, 2, 1'b0, 1'b1, 1'b1);
    chkv("two_starts", 8'(start_cnt - s0), 8'd2);
    for (int i = 0; i < 6; i++) begin
      do_txn(2'b11, 1 + (i % 3), 1'b1, logic'(i % 2), 1'b1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Stray fb_done while idle
    fb_done = 1'b1;
    tick();
    fb_done = 1'b0;
    chkb("spurious_busy", busy, 1'b0);
    chkv("spurious_pulses", 8'({fb_start, req0_ready, req1_ready, req0_done, req0_err, req1_done, req1_err}), 8'h00);
    tick();
    chkv("spurious_pulses2", 8'({busy, fb_start, req0_done, req0_err, req1_done, req1_err}), 8'h00);

    // Reset two cycles into WAIT, then the same command again
    set_cmd(1'b0, 8'h66, 8'h99, 1'b0, 8'h00, 8'h00);
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    chkb("midrst_ready", req0_ready, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chkb("midrst_fb_start", fb_start, 1'b0);
    chkb("midrst_busy", busy, 1'b0);
    chkv("midrst_pulses", 8'({req0_done, req0_err, req1_done, req1_err}), 8'h00);
    chkb("midrst_grant", grant_id, 1'b0);
    chkv("midrst_addr", fb_addr, 8'h00);
    rst = 1'b0;
    model_last = 1'b1;
    for (int i = 0; i < TO + 2; i++) begin
      tick();
      chkv("midrst_quiet", 8'({busy, req0_done, req0_err, req1_done, req1_err}), 8'h00);
    end
    do_txn(2'b01, 3, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      m  = 2'($urandom_range(1, 3));
      d  = int'($urandom_range(1, 14));
      kp = bit'($urandom_range(0, 1));
      set_cmd(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      w = model_pick(m);
      do_txn(m, d, kp, w, d <= TO);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
